// File: rtl/mux_rr_lanes.sv
// Serialises LANES buffered input lanes onto one registered output channel,
// using either fixed TDM slots or a round robin that skips empty lanes.
module mux_rr_lanes #(
  parameter int DATA_W    = 8,
  parameter int LANES     = 4,
  parameter int DEPTH     = 4,
  parameter int SKIP_IDLE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LANES*DATA_W-1:0]    dataIn,
  input  logic [LANES-1:0]           validIn,
  output logic [LANES-1:0]           readyIn,
  output logic [DATA_W-1:0]          dataOut,
  output logic                       validOut,
  output logic [$clog2(LANES)-1:0]   laneOut,
  input  logic                       readyOut,
  output logic                       overflow
);

  localparam int LW = $clog2(LANES);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q    [LANES][DEPTH];
  logic [DATA_W-1:0] mem_d    [LANES][DEPTH];
  logic [AW-1:0]     wr_ptr_q [LANES];
  logic [AW-1:0]     wr_ptr_d [LANES];
  logic [AW-1:0]     rd_ptr_q [LANES];
  logic [AW-1:0]     rd_ptr_d [LANES];
  logic [CW-1:0]     cnt_q    [LANES];
  logic [CW-1:0]     cnt_d    [LANES];

  logic [LW-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic              vout_q, vout_d;
  logic              ovf_q, ovf_d;

  logic [LANES-1:0]  full, empty, wr_en, pop_en;
  logic              load, found;
  logic [LW-1:0]     cand, idx;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      full[i]  = (cnt_q[i] == CW'(DEPTH));
      empty[i] = (cnt_q[i] == '0);
      wr_en[i] = validIn[i] && !full[i];
    end
  end

  // Full is judged on the registered count only, so a pop cannot free a slot
  // for a write in the same cycle.
  assign readyIn = reset ? '0 : ~full;

  always_comb begin
    load  = !vout_q || readyOut;
    cand  = ptr_q;
    found = 1'b0;
    idx   = '0;
    if (SKIP_IDLE != 0) begin
      // Walk backwards so the nearest non-empty lane from ptr wins last.
      for (int k = LANES - 1; k >= 0; k--) begin
        idx = ptr_q + LW'(k);
        if (!empty[idx]) begin
          cand  = idx;
          found = 1'b1;
        end
      end
    end else begin
      found = !empty[ptr_q];
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    dout_d = dout_q;
    lane_d = lane_q;
    vout_d = vout_q;
    ovf_d  = ovf_q | (|(validIn & full));
    if (load) begin
      if (SKIP_IDLE != 0) begin
        if (found) ptr_d = cand + 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
      if (found) begin
        dout_d = mem_q[cand][rd_ptr_q[cand]];
        lane_d = cand;
        vout_d = 1'b1;
      end else begin
        vout_d = 1'b0;
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < LANES; i++) begin
      pop_en[i]   = load && found && (cand == LW'(i));
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      if (wr_en[i]) begin
        mem_d[i][wr_ptr_q[i]] = dataIn[i*DATA_W +: DATA_W];
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (pop_en[i]) rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      cnt_d[i] = cnt_q[i] + CW'(wr_en[i]) - CW'(pop_en[i]);
    end
  end

  // Storage needs no reset: a lane is never read while its count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ptr_q  <= '0;
      dout_q <= '0;
      lane_q <= '0;
      vout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      ptr_q  <= ptr_d;
      dout_q <= dout_d;
      lane_q <= lane_d;
      vout_q <= vout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dataOut  = dout_q;
  assign laneOut  = lane_q;
  assign validOut = vout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mux_rr_lanes.sv
// Directed bench for mux_rr_lanes: one TDM instance and one skip-idle instance,
// with per-instance expected-word queues checked as words leave the output.
module tb_mux_rr_lanes;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [31:0] di0 = '0, di1 = '0;
  logic [3:0]  vi0 = '0, vi1 = '0;
  logic [3:0]  ri0, ri1;
  logic [7:0]  do0, do1;
  logic        vo0, vo1;
  logic [1:0]  lo0, lo1;
  logic        ro0 = 1'b1, ro1 = 1'b1;
  logic        ov0, ov1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] e0, e1;
  logic [1:0] p0 = '0;

  always #5 clk = ~clk;

  mux_rr_lanes #(.DATA_W(8), .LANES(4), .DEPTH(4), .SKIP_IDLE(0)) u_tdm (
    .clk(clk), .reset(rst), .dataIn(di0), .validIn(vi0), .readyIn(ri0),
    .dataOut(do0), .validOut(vo0), .laneOut(lo0), .readyOut(ro0), .overflow(ov0)
  );

  mux_rr_lanes #(.DATA_W(8), .LANES(4), .DEPTH(4), .SKIP_IDLE(1)) u_rr (
    .clk(clk), .reset(rst), .dataIn(di1), .validIn(vi1), .readyIn(ri1),
    .dataOut(do1), .validOut(vo1), .laneOut(lo1), .readyOut(ro1), .overflow(ov1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // p0 mirrors the TDM slot pointer; it only stalls while the output holds a word.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ro0) p0 = p0 + 2'd1;
  endtask

  task automatic align0(input logic [1:0] target);
    for (int n = 0; n < 4 && p0 != target; n++) tick();
  endtask

  always @(negedge clk) begin
    if (!rst && vo0 && ro0) begin
      if (q0.size() == 0) chk("tdm_extra_word", 32'(q0.size()), 32'd1);
      else begin
        e0 = q0.pop_front();
        chk("tdm_sb_data", 32'(do0), 32'(e0[7:0]));
        chk("tdm_sb_lane", 32'(lo0), 32'(e0[9:8]));
      end
    end
    if (!rst && vo1 && ro1) begin
      if (q1.size() == 0) chk("rr_extra_word", 32'(q1.size()), 32'd1);
      else begin
        e1 = q1.pop_front();
        chk("rr_sb_data", 32'(do1), 32'(e1[7:0]));
        chk("rr_sb_lane", 32'(lo1), 32'(e1[9:8]));
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_dout", 32'(do0), 32'h0);
    chk("rst_vout", 32'(vo0), 32'h0);
    chk("rst_lane", 32'(lo0), 32'h0);
    chk("rst_ovf",  32'(ov0), 32'h0);
    chk("rst_rdy",  32'(ri0), 32'h0);
    chk("rst_rdy_rr", 32'(ri1), 32'h0);
    #10 rst = 1'b0;
    p0 = '0;
    #1;
    chk("rel_rdy", 32'(ri0), 32'hF);
    chk("rel_rdy_rr", 32'(ri1), 32'hF);

    // Fill all four TDM lanes so lane 0 is the next slot
    q0.push_back({2'd0, 8'h10});
    q0.push_back({2'd1, 8'h20});
    q0.push_back({2'd2, 8'h30});
    q0.push_back({2'd3, 8'h40});
    align0(2'd3);
    vi0 = 4'hF;
    di0 = 32'h40302010;
    tick();
    vi0 = '0;
    chk("fill_nobypass", 32'(vo0), 32'h0);
    tick();
    chk("fill_d0", 32'(do0), 32'h10);
    chk("fill_l0", 32'(lo0), 32'h0);
    chk("fill_v0", 32'(vo0), 32'h1);
    tick();
    chk("fill_d1", 32'(do0), 32'h20);
    chk("fill_l1", 32'(lo0), 32'h1);

    // Backpressure on 0x20 while lane 1 is filled past capacity
    ro0 = 1'b0;
    chk("ovf_rdy_pre", 32'(ri0[1]), 32'h1);
    for (int i = 0; i < 5; i++) begin
      vi0 = 4'b0010;
      di0[15:8] = 8'(8'hB1 + i);
      if (i < 4) q0.push_back({2'd1, 8'(8'hB1 + i)});
      tick();
      chk("bp_dout", 32'(do0), 32'h20);
      chk("bp_lane", 32'(lo0), 32'h1);
      chk("bp_vout", 32'(vo0), 32'h1);
      if (i == 3) begin
        chk("ovf_rdy_full", 32'(ri0[1]), 32'h0);
        chk("ovf_not_yet", 32'(ov0), 32'h0);
      end
      if (i == 4) chk("ovf_set", 32'(ov0), 32'h1);
    end
    vi0 = '0;
    ro0 = 1'b1;
    tick();
    chk("bp_next_d", 32'(do0), 32'h30);
    chk("bp_next_l", 32'(lo0), 32'h2);
    tick();
    chk("fill_d3", 32'(do0), 32'h40);
    chk("fill_l3", 32'(lo0), 32'h3);
    for (int i = 0; i < 16; i++) tick();
    chk("drain_done", 32'(q0.size()), 32'h0);
    chk("drain_rdy", 32'(ri0[1]), 32'h1);
    chk("ovf_sticky", 32'(ov0), 32'h1);

    // TDM empty slots: only lane 2 occupied
    q0.push_back({2'd2, 8'hAA});
    align0(2'd3);
    vi0 = 4'b0100;
    di0 = 32'h00AA0000;
    tick();
    vi0 = '0;
    tick();
    chk("slot0_v", 32'(vo0), 32'h0);
    tick();
    chk("slot1_v", 32'(vo0), 32'h0);
    tick();
    chk("slot2_v", 32'(vo0), 32'h1);
    chk("slot2_d", 32'(do0), 32'hAA);
    chk("slot2_l", 32'(lo0), 32'h2);
    tick();
    chk("slot3_v", 32'(vo0), 32'h0);
    chk("slot3_hold", 32'(do0), 32'hAA);

    // Pointer wrapped to 0: a lane 0 write misses this slot and lands 4 later
    q0.push_back({2'd0, 8'h77});
    vi0 = 4'b0001;
    di0 = 32'h00000077;
    tick();
    vi0 = '0;
    chk("wrap_nobypass", 32'(vo0), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("wrap_v", 32'(vo0), 32'h1);
    chk("wrap_d", 32'(do0), 32'h77);
    chk("wrap_l", 32'(lo0), 32'h0);

    // Skip-idle mode: lane 3 only
    q1.push_back({2'd3, 8'h55});
    q1.push_back({2'd3, 8'h66});
    vi1 = 4'b1000;
    di1 = 32'h55000000;
    tick();
    chk("rr_nobypass", 32'(vo1), 32'h0);
    di1 = 32'h66000000;
    tick();
    vi1 = '0;
    chk("rr_d55", 32'(do1), 32'h55);
    chk("rr_l55", 32'(lo1), 32'h3);
    chk("rr_v55", 32'(vo1), 32'h1);
    tick();
    chk("rr_d66", 32'(do1), 32'h66);
    chk("rr_l66", 32'(lo1), 32'h3);
    tick();
    chk("rr_idle", 32'(vo1), 32'h0);

    // After granting lane 3 the pointer is 0, so lane 1 precedes lane 3
    q1.push_back({2'd1, 8'hC1});
    q1.push_back({2'd3, 8'hC3});
    vi1 = 4'b1010;
    di1 = 32'hC300C100;
    tick();
    vi1 = '0;
    tick();
    chk("rr_ptr_d1", 32'(do1), 32'hC1);
    chk("rr_ptr_l1", 32'(lo1), 32'h1);
    tick();
    chk("rr_ptr_d3", 32'(do1), 32'hC3);
    chk("rr_ptr_l3", 32'(lo1), 32'h3);

    // Full burst: one word per cycle
    for (int i = 0; i < 4; i++) q1.push_back({2'(i), 8'(8'hD0 + i)});
    vi1 = 4'hF;
    di1 = 32'hD3D2D1D0;
    tick();
    vi1 = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_burst_v", 32'(vo1), 32'h1);
      chk("rr_burst_d", 32'(do1), 32'(8'hD0 + i));
      chk("rr_burst_l", 32'(lo1), 32'(i));
    end
    tick();
    chk("rr_burst_end", 32'(vo1), 32'h0);

    // Mid-stream reset with three words buffered behind a stalled output
    ro0 = 1'b0;
    vi0 = 4'hF;
    di0 = 32'hE3E2E1E0;
    tick();
    vi0 = '0;
    tick();
    chk("mid_stalled_v", 32'(vo0), 32'h1);
    #3 rst = 1'b1;
    #1;
    chk("mid_vout", 32'(vo0), 32'h0);
    chk("mid_ovf",  32'(ov0), 32'h0);
    chk("mid_rdy",  32'(ri0), 32'h0);
    chk("mid_dout", 32'(do0), 32'h0);
    #7 rst = 1'b0;
    p0 = '0;
    ro0 = 1'b1;
    #1;
    chk("mid_rel_rdy", 32'(ri0), 32'hF);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_no_stale", 32'(vo0), 32'h0);
    end

    chk("q0_empty", 32'(q0.size()), 32'h0);
    chk("q1_empty", 32'(q1.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
